// File: rtl/smc_pwm_core.sv
// Stepper-motor PWM core: Q-bus register file, shared prescaled period counter and
// NCH double-buffered PWM channels driving complementary MNM/MNP coil pins.
module smc_pwm_core #(
    parameter int NCH = 12,
    parameter int CW  = 11
) (
    input  logic           QCLK,
    input  logic           QRESET,
    input  logic           QSEL,
    input  logic           QWRITE,
    input  logic [6:0]     QADDR,
    input  logic [15:0]    QDATAIN,
    output logic [15:0]    QDATAOUT,
    output logic [NCH-1:0] MNM,
    output logic [NCH-1:0] MNP,
    output logic           IRQ
);

    localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [6:0]    ADDR_CTL0 = 7'h00;
    localparam logic [6:0]    ADDR_CTL1 = 7'h01;
    localparam logic [6:0]    ADDR_PER  = 7'h02;

    logic wr_en;
    logic rd_en;
    logic wr_ctl0;
    logic wr_ctl1;
    logic wr_per;

    assign wr_en   = QSEL & QWRITE;
    assign rd_en   = QSEL & ~QWRITE;
    assign wr_ctl0 = wr_en && (QADDR == ADDR_CTL0);
    assign wr_ctl1 = wr_en && (QADDR == ADDR_CTL1);
    assign wr_per  = wr_en && (QADDR == ADDR_PER);

    // Control register MCCTL0 / MCCTL1
    logic       mcen_reg, mcen_next;
    logic [1:0] pre_reg, pre_next;
    logic       toie_reg, toie_next;
    logic       toif_reg, toif_next;

    // Period: shadow written by software, active used by the counter
    logic [CW-1:0] per_sh_reg, per_sh_next;
    logic [CW-1:0] per_act_reg, per_act_next;

    // Counter and prescaler
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [2:0]    presc_reg, presc_next;
    logic [2:0]    presc_max;
    logic          run;
    logic          tick;
    logic          wrap;
    logic          load;

    // Counting stalls when disabled or when the live period is zero.
    assign run  = mcen_reg && (per_act_reg != '0);
    assign tick = run && (presc_reg == presc_max);
    assign wrap = tick && (cnt_reg == (per_act_reg - CNT_ONE));
    // While stalled the active copies follow the shadows; while running only at wrap.
    assign load = ~run | wrap;

    always_comb begin
        presc_max = 3'd0;
        case (pre_reg)
            2'd0:    presc_max = 3'd0;
            2'd1:    presc_max = 3'd1;
            2'd2:    presc_max = 3'd3;
            default: presc_max = 3'd7;
        endcase
    end

    always_comb begin
        mcen_next = mcen_reg;
        pre_next  = pre_reg;
        toie_next = toie_reg;
        if (wr_ctl0) begin
            mcen_next = QDATAIN[0];
            pre_next  = QDATAIN[2:1];
            toie_next = QDATAIN[7];
        end
        // A wrap in the same cycle as a clear keeps the flag set.
        toif_next = toif_reg;
        if (wrap) begin
            toif_next = 1'b1;
        end else if (wr_ctl1 && QDATAIN[0]) begin
            toif_next = 1'b0;
        end
    end

    always_comb begin
        per_sh_next  = wr_per ? QDATAIN[CW-1:0] : per_sh_reg;
        per_act_next = load ? per_sh_next : per_act_reg;
    end

    always_comb begin
        cnt_next   = cnt_reg;
        presc_next = presc_reg;
        if (!run) begin
            cnt_next   = '0;
            presc_next = '0;
        end else if (tick) begin
            presc_next = '0;
            cnt_next   = wrap ? '0 : (cnt_reg + CNT_ONE);
        end else begin
            presc_next = presc_reg + 3'd1;
        end
    end

    always_ff @(posedge QCLK or posedge QRESET) begin
        if (QRESET) begin
            mcen_reg <= 1'b0;
            pre_reg  <= 2'd0;
            toie_reg <= 1'b0;
            toif_reg <= 1'b0;
        end else begin
            mcen_reg <= mcen_next;
            pre_reg  <= pre_next;
            toie_reg <= toie_next;
            toif_reg <= toif_next;
        end
    end

    always_ff @(posedge QCLK or posedge QRESET) begin
        if (QRESET) begin
            per_sh_reg  <= '0;
            per_act_reg <= '0;
            cnt_reg     <= '0;
            presc_reg   <= '0;
        end else begin
            per_sh_reg  <= per_sh_next;
            per_act_reg <= per_act_next;
            cnt_reg     <= cnt_next;
            presc_reg   <= presc_next;
        end
    end

    // Per-channel read contributions, OR-combined into the read mux
    logic [NCH-1:0][15:0] ch_rd_bus;

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : gen_ch
            localparam logic [6:0] CC_ADDR = 7'(16 + gi);
            localparam logic [6:0] DC_ADDR = 7'(32 + gi);

            logic          cc_sel;
            logic          dc_sel;
            logic [1:0]    mcam_reg, mcam_next;
            logic [CW-1:0] duty_sh_reg, duty_sh_next;
            logic          sign_sh_reg, sign_sh_next;
            logic [CW-1:0] duty_act_reg, duty_act_next;
            logic          sign_act_reg, sign_act_next;
            logic          mnm_reg, mnm_next;
            logic          mnp_reg, mnp_next;
            logic          pwm;

            // One extra bit keeps L+E and PER-E exact when E equals PER.
            logic [CW:0] d_ext;
            logic [CW:0] p_ext;
            logic [CW:0] c_ext;
            logic [CW:0] e_val;
            logic [CW:0] rem_val;
            logic [CW:0] lead_val;
            logic [CW:0] end_val;

            assign cc_sel = (QADDR == CC_ADDR);
            assign dc_sel = (QADDR == DC_ADDR);

            always_comb begin
                mcam_next    = (wr_en && cc_sel) ? QDATAIN[1:0] : mcam_reg;
                duty_sh_next = (wr_en && dc_sel) ? QDATAIN[CW-1:0] : duty_sh_reg;
                sign_sh_next = (wr_en && dc_sel) ? QDATAIN[15] : sign_sh_reg;
                duty_act_next = load ? duty_sh_next : duty_act_reg;
                sign_act_next = load ? sign_sh_next : sign_act_reg;
            end

            assign d_ext    = {1'b0, duty_act_reg};
            assign p_ext    = {1'b0, per_act_reg};
            assign c_ext    = {1'b0, cnt_reg};
            assign e_val    = (d_ext < p_ext) ? d_ext : p_ext;
            assign rem_val  = p_ext - e_val;
            assign lead_val = rem_val >> 1;
            assign end_val  = lead_val + e_val;

            always_comb begin
                pwm = 1'b0;
                case (mcam_reg)
                    2'b01:   pwm = (c_ext < e_val);
                    2'b10:   pwm = (c_ext >= rem_val);
                    2'b11:   pwm = (c_ext >= lead_val) && (c_ext < end_val);
                    default: pwm = 1'b0;
                endcase
                if (!run) begin
                    pwm = 1'b0;
                end
                mnp_next = pwm & ~sign_act_reg;
                mnm_next = pwm & sign_act_reg;
            end

            always_ff @(posedge QCLK or posedge QRESET) begin
                if (QRESET) begin
                    mcam_reg     <= 2'b00;
                    duty_sh_reg  <= '0;
                    sign_sh_reg  <= 1'b0;
                    duty_act_reg <= '0;
                    sign_act_reg <= 1'b0;
                    mnm_reg      <= 1'b0;
                    mnp_reg      <= 1'b0;
                end else begin
                    mcam_reg     <= mcam_next;
                    duty_sh_reg  <= duty_sh_next;
                    sign_sh_reg  <= sign_sh_next;
                    duty_act_reg <= duty_act_next;
                    sign_act_reg <= sign_act_next;
                    mnm_reg      <= mnm_next;
                    mnp_reg      <= mnp_next;
                end
            end

            assign MNM[gi] = mnm_reg;
            assign MNP[gi] = mnp_reg;

            assign ch_rd_bus[gi] = cc_sel ? {14'h0, mcam_reg} :
                                   dc_sel ? {sign_sh_reg, 15'(duty_sh_reg)} :
                                            16'h0000;
        end
    endgenerate

    logic [15:0] ch_rd;
    logic [15:0] rd_data;

    always_comb begin
        ch_rd = 16'h0000;
        for (int i = 0; i < NCH; i++) begin
            ch_rd = ch_rd | ch_rd_bus[i];
        end
    end

    always_comb begin
        rd_data = 16'h0000;
        if (rd_en) begin
            case (QADDR)
                ADDR_CTL0: rd_data = {8'h00, toie_reg, 4'h0, pre_reg, mcen_reg};
                ADDR_CTL1: rd_data = {15'h0000, toif_reg};
                ADDR_PER:  rd_data = 16'(per_sh_reg);
                default:   rd_data = ch_rd;
            endcase
        end
    end

    assign QDATAOUT = rd_data;
    assign IRQ      = toif_reg & toie_reg;

    // Not every data bit belongs to a field.
    logic unused_qdata;
    assign unused_qdata = ^QDATAIN;

endmodule

// File: tb/tb_smc_pwm_core.sv
// Scoreboard bench for smc_pwm_core: stimulus queues expected reads, pin states and
// IRQ levels; a negedge monitor pops and compares them.
module tb_smc_pwm_core;

    localparam int NCH = 12;
    localparam int CW  = 11;

    logic           QCLK;
    logic           QRESET;
    logic           QSEL;
    logic           QWRITE;
    logic [6:0]     QADDR;
    logic [15:0]    QDATAIN;
    logic [15:0]    QDATAOUT;
    logic [NCH-1:0] MNM;
    logic [NCH-1:0] MNP;
    logic           IRQ;

    smc_pwm_core #(.NCH(NCH), .CW(CW)) dut (
        .QCLK    (QCLK),
        .QRESET  (QRESET),
        .QSEL    (QSEL),
        .QWRITE  (QWRITE),
        .QADDR   (QADDR),
        .QDATAIN (QDATAIN),
        .QDATAOUT(QDATAOUT),
        .MNM     (MNM),
        .MNP     (MNP),
        .IRQ     (IRQ)
    );

    initial QCLK = 1'b0;
    always #5 QCLK = ~QCLK;

    typedef struct packed {
        logic [6:0]  addr;
        logic [15:0] data;
    } rd_exp_t;

    typedef struct packed {
        logic [NCH-1:0] mnp;
        logic [NCH-1:0] mnm;
    } pin_exp_t;

    rd_exp_t  rd_q[$];
    pin_exp_t pin_q[$];
    logic     irq_q[$];

    logic pin_chk;
    logic irq_chk;
    logic done;
    logic final_done;
    int   total;
    int   bad;

    rd_exp_t  mon_rd;
    pin_exp_t mon_pin;
    logic     mon_irq;

    // Pattern words: [0] ch0 MNP, [1] ch1 MNP, [2] ch2 MNP, [3] ch0 MNM; bit c = CNT value c
    logic [3:0][15:0] pat_base;
    logic [3:0][15:0] pat_d7;
    logic [3:0][15:0] pat_p6;
    logic [3:0][15:0] pat_neg5;
    logic [3:0][15:0] pat_full;
    logic [3:0][15:0] pat_zero;

    always @(negedge QCLK) begin
        if (QSEL && !QWRITE) begin
            total++;
            if (rd_q.size() == 0) begin
                bad++;
                $display("FAIL rd_underflow addr=%02h got=%04h", QADDR, QDATAOUT);
            end else begin
                mon_rd = rd_q.pop_front();
                if (QDATAOUT !== mon_rd.data || QADDR !== mon_rd.addr) begin
                    bad++;
                    $display("FAIL rd addr=%02h got=%04h want=%04h (queued addr %02h)",
                             QADDR, QDATAOUT, mon_rd.data, mon_rd.addr);
                end else begin
                    $display("ok rd addr=%02h data=%04h", QADDR, QDATAOUT);
                end
            end
        end
        if (pin_chk) begin
            total++;
            if (pin_q.size() == 0) begin
                bad++;
                $display("FAIL pin_underflow mnp=%03h mnm=%03h", MNP, MNM);
            end else begin
                mon_pin = pin_q.pop_front();
                if (MNP !== mon_pin.mnp || MNM !== mon_pin.mnm) begin
                    bad++;
                    $display("FAIL pins t=%0t got mnp=%03h mnm=%03h want mnp=%03h mnm=%03h",
                             $time, MNP, MNM, mon_pin.mnp, mon_pin.mnm);
                end else begin
                    $display("ok pins t=%0t mnp=%03h mnm=%03h", $time, MNP, MNM);
                end
            end
        end
        if (irq_chk) begin
            total++;
            if (irq_q.size() == 0) begin
                bad++;
                $display("FAIL irq_underflow irq=%0b", IRQ);
            end else begin
                mon_irq = irq_q.pop_front();
                if (IRQ !== mon_irq) begin
                    bad++;
                    $display("FAIL irq t=%0t got=%0b want=%0b", $time, IRQ, mon_irq);
                end else begin
                    $display("ok irq t=%0t irq=%0b", $time, IRQ);
                end
            end
        end
        if (done && !final_done) begin
            final_done = 1'b1;
            total++;
            if (rd_q.size() != 0 || pin_q.size() != 0 || irq_q.size() != 0) begin
                bad++;
                $display("FAIL leftover rd=%0d pin=%0d irq=%0d want all 0",
                         rd_q.size(), pin_q.size(), irq_q.size());
            end
        end
    end

    task automatic step();
        @(posedge QCLK);
        #1;
        QSEL    = 1'b0;
        QWRITE  = 1'b0;
        QADDR   = 7'h00;
        QDATAIN = 16'h0000;
        pin_chk = 1'b0;
        irq_chk = 1'b0;
    endtask

    task automatic drive_wr(input logic [6:0] a, input logic [15:0] d);
        QSEL    = 1'b1;
        QWRITE  = 1'b1;
        QADDR   = a;
        QDATAIN = d;
    endtask

    task automatic drive_rd(input logic [6:0] a, input logic [15:0] e);
        rd_exp_t r;
        QSEL   = 1'b1;
        QWRITE = 1'b0;
        QADDR  = a;
        r.addr = a;
        r.data = e;
        rd_q.push_back(r);
    endtask

    task automatic wr(input logic [6:0] a, input logic [15:0] d);
        drive_wr(a, d);
        step();
    endtask

    task automatic rd(input logic [6:0] a, input logic [15:0] e);
        drive_rd(a, e);
        step();
    endtask

    task automatic chk_pins(input logic [NCH-1:0] p, input logic [NCH-1:0] m);
        pin_exp_t x;
        x.mnp = p;
        x.mnm = m;
        pin_q.push_back(x);
        pin_chk = 1'b1;
    endtask

    task automatic chk_irq(input logic v);
        irq_q.push_back(v);
        irq_chk = 1'b1;
    endtask

    // Called right after the MCEN=1 write. Cycle j shows the pins for CNT of cycle j-1.
    // Output index m < sw uses period per_a / pat_a, later ones per_b / pat_b.
    task automatic run_pins(input int ncyc, input int per_a, input int per_b, input int sw,
                            input logic [3:0][15:0] pa, input logic [3:0][15:0] pb,
                            input int wr_i, input logic [6:0] wa, input logic [15:0] wd);
        logic [NCH-1:0]   ep;
        logic [NCH-1:0]   em;
        logic [3:0][15:0] pat;
        int m;
        int c;
        for (int j = 0; j < ncyc; j++) begin
            if (j == wr_i) drive_wr(wa, wd);
            ep = '0;
            em = '0;
            if (j > 0) begin
                m = j - 1;
                if (m < sw) begin
                    c   = m % per_a;
                    pat = pa;
                end else begin
                    c   = (m - sw) % per_b;
                    pat = pb;
                end
                ep[0] = pat[0][c];
                ep[1] = pat[1][c];
                ep[2] = pat[2][c];
                em[0] = pat[3][c];
            end
            chk_pins(ep, em);
            step();
        end
    endtask

    task automatic base_cfg();
        wr(7'h02, 16'd10);
        wr(7'h10, 16'h0001);
        wr(7'h20, 16'h0003);
        wr(7'h11, 16'h0002);
        wr(7'h21, 16'h0003);
        wr(7'h12, 16'h0003);
        wr(7'h22, 16'h0004);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        QRESET = 1'b1; QSEL = 1'b0; QWRITE = 1'b0; QADDR = 7'h00; QDATAIN = 16'h0000;
        pin_chk = 1'b0; irq_chk = 1'b0; done = 1'b0; final_done = 1'b0;
        total = 0; bad = 0;
        pat_base = {16'h0000, 16'h0078, 16'h0380, 16'h0007};
        pat_d7   = {16'h0000, 16'h0078, 16'h0380, 16'h007F};
        pat_p6   = {16'h0000, 16'h001E, 16'h0038, 16'h0007};
        pat_neg5 = {16'h001F, 16'h0078, 16'h0380, 16'h0000};
        pat_full = {16'h0000, 16'h0078, 16'h0380, 16'h03FF};
        pat_zero = {16'h0000, 16'h0078, 16'h0380, 16'h0000};

        // Reset state
        step();
        chk_pins('0, '0);
        chk_irq(1'b0);
        drive_rd(7'h00, 16'h0000);
        step();
        QRESET = 1'b0;
        rd(7'h02, 16'h0000);

        // Register map, field masking, unmapped addresses
        base_cfg();
        wr(7'h02, 16'hF00A);
        wr(7'h05, 16'hFFFF);
        wr(7'h1D, 16'h0003);
        wr(7'h2D, 16'h8005);
        rd(7'h02, 16'h000A);
        rd(7'h22, 16'h0004);
        rd(7'h11, 16'h0002);
        rd(7'h21, 16'h0003);
        rd(7'h05, 16'h0000);
        rd(7'h1D, 16'h0000);
        rd(7'h2D, 16'h0000);
        rd(7'h7F, 16'h0000);

        // Left / right / center on PER=10
        wr(7'h00, 16'h0001);
        run_pins(22, 10, 10, 1000, pat_base, pat_base, -1, 7'h00, 16'h0000);

        // Disable: outputs clear one edge after MCEN reads 0
        wr(7'h00, 16'h0000);
        step();
        chk_pins('0, '0);
        step();

        // Duty 3 -> 7 written at CNT=5: takes effect next period
        wr(7'h00, 16'h0001);
        run_pins(31, 10, 10, 10, pat_base, pat_d7, 5, 7'h20, 16'h0007);
        wr(7'h00, 16'h0000);
        wr(7'h20, 16'h0003);

        // Duty write landing in the wrap cycle loads immediately
        wr(7'h00, 16'h0001);
        run_pins(25, 10, 10, 10, pat_base, pat_d7, 9, 7'h20, 16'h0007);
        wr(7'h00, 16'h0000);
        wr(7'h20, 16'h0003);

        // Period 10 -> 6 mid-period
        wr(7'h00, 16'h0001);
        run_pins(24, 10, 6, 10, pat_base, pat_p6, 5, 7'h02, 16'h0006);
        wr(7'h00, 16'h0000);
        wr(7'h02, 16'd10);

        // Negative sign and duty saturation
        wr(7'h20, 16'h8005);
        rd(7'h20, 16'h8005);
        wr(7'h00, 16'h0001);
        run_pins(12, 10, 10, 1000, pat_neg5, pat_neg5, -1, 7'h00, 16'h0000);
        wr(7'h00, 16'h0000);
        wr(7'h20, 16'h000A);
        wr(7'h00, 16'h0001);
        run_pins(12, 10, 10, 1000, pat_full, pat_full, -1, 7'h00, 16'h0000);
        wr(7'h00, 16'h0000);
        wr(7'h20, 16'h7FFF);
        rd(7'h20, 16'h07FF);
        wr(7'h00, 16'h0001);
        run_pins(12, 10, 10, 1000, pat_full, pat_full, -1, 7'h00, 16'h0000);
        wr(7'h00, 16'h0000);
        wr(7'h20, 16'h0000);
        wr(7'h00, 16'h0001);
        run_pins(12, 10, 10, 1000, pat_zero, pat_zero, -1, 7'h00, 16'h0000);

        // Interrupt: PER=4, PRE=2 wraps every 16 cycles
        wr(7'h00, 16'h0000);
        wr(7'h20, 16'h0003);
        wr(7'h01, 16'h0001);
        wr(7'h02, 16'h0004);
        wr(7'h00, 16'hFF85);
        for (int j = 0; j < 36; j++) begin
            if (j <= 16) chk_irq(j == 16);
            case (j)
                17: drive_rd(7'h01, 16'h0001);
                18: drive_wr(7'h01, 16'h0000);
                19: begin drive_rd(7'h01, 16'h0001); chk_irq(1'b1); end
                20: drive_wr(7'h01, 16'h0001);
                21: begin drive_rd(7'h01, 16'h0000); chk_irq(1'b0); end
                22: drive_rd(7'h00, 16'h0085);
                31: drive_wr(7'h01, 16'h0001);
                32: begin drive_rd(7'h01, 16'h0001); chk_irq(1'b1); end
                33: chk_irq(1'b1);
                default: ;
            endcase
            step();
        end

        // Asynchronous reset mid-period with active outputs
        wr(7'h00, 16'h0000);
        wr(7'h01, 16'h0001);
        wr(7'h02, 16'd10);
        wr(7'h00, 16'h0001);
        run_pins(7, 10, 10, 1000, pat_base, pat_base, -1, 7'h00, 16'h0000);
        QRESET = 1'b1;
        chk_pins('0, '0);
        chk_irq(1'b0);
        step();
        QRESET = 1'b0;
        rd(7'h00, 16'h0000);
        rd(7'h01, 16'h0000);
        rd(7'h02, 16'h0000);
        rd(7'h10, 16'h0000);
        rd(7'h20, 16'h0000);
        rd(7'h22, 16'h0000);
        for (int j = 0; j < 6; j++) begin
            chk_pins('0, '0);
            step();
        end
        wr(7'h00, 16'h0001);
        for (int j = 0; j < 6; j++) begin
            chk_pins('0, '0);
            step();
        end

        // Software restarts after reset
        wr(7'h00, 16'h0000);
        base_cfg();
        wr(7'h00, 16'h0001);
        run_pins(12, 10, 10, 1000, pat_base, pat_base, -1, 7'h00, 16'h0000);

        done = 1'b1;
        step();
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/smc_pwm_core.md
# smc_pwm_core

Parametrised stepper-motor PWM core: the next-generation motor-controller datapath behind the Q-bus register interface. It holds a shared period counter plus NCH channels with per-channel alignment mode, signed duty cycles and double-buffered updates. It drives each channel's MNM/MNP coil pins and flags a period-wrap interrupt. It replaces the fixed-pattern output generator in the SMC subsystem.

## Interface
- NCH, 12: channel count, 1..16.
- CW, 11: counter/period/duty width, 4..15.
- QCLK  in  1  clock; all logic on posedge.
- QRESET  in  1  asynchronous, active-high reset.
- QSEL  in  1  register access select.
- QWRITE  in  1  1 = write, 0 = read (valid with QSEL).
- QADDR  in  7  register address.
- QDATAIN  in  16  write data.
- QDATAOUT  out  16  read data.
- MNM  out  NCH  minus-side coil drive per channel.
- MNP  out  NCH  plus-side coil drive per channel.
- IRQ  out  1  TOIF & TOIE.

## Operation
- Register map. Unmapped addresses read 0 and ignore writes. Bits outside the fields below read 0.
  - 0x00 MCCTL0: [0] MCEN global enable; [2:1] PRE, counter tick every 2^PRE QCLK cycles; [7] TOIE.
  - 0x01 MCCTL1: [0] TOIF. Write 1 clears; write 0 has no effect.
  - 0x02 MCPER: [CW-1:0] shadow period.
  - 0x10+ch MCCCch: [1:0] MCAM. 00 = off, 01 = left, 10 = right, 11 = center.
  - 0x20+ch MCDCch: [15] S sign; [CW-1:0] shadow duty D.
- Write: when QSEL & QWRITE, the register updates at posedge. Read: QDATAOUT is combinational when QSEL & !QWRITE, else 0. MCPER and MCDC reads return shadow values.
- Counter CNT (CW bits) has two cases:
  - MCEN=0 or active PER=0: CNT and prescaler held at 0. Active PER/duty/sign track their shadows every cycle.
  - Otherwise, on each tick: if CNT == PER-1, CNT goes to 0 (wrap); else CNT increments.
- At wrap:
  - Active PER and all active D/S load from their shadows.
  - TOIF sets. A same-cycle write-1-clear loses; set wins.
- Per-channel pwm, with E = min(D, PER):
  - left: pwm = CNT < E.
  - right: pwm = CNT >= PER-E.
  - center: L = (PER-E)>>1, truncated; pwm = CNT >= L && CNT < L+E.
  - off, MCEN=0 or PER=0: pwm = 0.
- Drive:
  - S=0: MNP = pwm, MNM = 0.
  - S=1: MNM = pwm, MNP = 0.
  - MNM[ch] and MNP[ch] are never both 1.
- Arithmetic is unsigned in CW+1 bits, with no overflow at E = PER.

## Timing
- Reset values: all registers 0, CNT 0, prescaler 0, MNM = MNP = 0, IRQ = 0, QDATAOUT = 0.
- Outputs are registered. MNM/MNP in cycle k+1 reflect CNT and active values of cycle k.
- Write to MCEN=1 at edge k:
  - CNT = 0 in cycle k+1.
  - First tick at edge k+1 for PRE=0.
  - First output edge at edge k+1.
- With PRE=p, CNT changes every 2^p cycles. The prescaler restarts at 0 on each 0→1 transition of MCEN.
- Shadow write mid-period: the old active value holds until the wrap. Exception: the write lands in the wrap cycle itself; the write then completes first and the new value loads.
- TOIF rises in the cycle after the wrap edge. IRQ is combinational from TOIF/TOIE.
- MCEN 1→0: CNT goes to 0 and outputs go to 0 on the next edge.
- QRESET mid-period: immediate asynchronous clear of everything. Operation resumes only after software re-enables.

## Test plan
- PER=10, PRE=0, ch0 left, D=3, S=0, MCEN=1 -> MNP[0] high 3 of every 10 cycles (CNT 0..2); MNM[0] = 0; all other channels 0.
- Same setup, ch1 right D=3 and ch2 center D=4 -> ch1 high at CNT 7..9; ch2 high at CNT 3..6. CNT=4 on ch0 is low.
- ch0 MCDC = 0x8005, PER=10 -> MNM[0] high at CNT 0..4, MNP[0] = 0. D=10 and D=0x7FF -> constant 1; D=0 -> constant 0.
- Write ch0 D=3→7 at CNT=5 -> D=3 behaviour through CNT 9; D=7 from the next period. MCPER 10→6 mid-period -> wrap at CNT 9, then period 6.
- TOIE=1, PER=4, PRE=2 -> wrap every 16 cycles; TOIF=1 and IRQ=1. Write 0x01 to MCCTL1 -> both clear. Write-1-clear in a wrap cycle -> TOIF stays 1.
- Assert QRESET with CNT=7 and outputs active -> all outputs 0 immediately; all register reads 0 afterwards; MNM/MNP stay 0 until MCEN is rewritten.
